// File: rtl/gerenciador_servos_pkg.sv
// Shared definitions for the servo sequencer: FSM state codes and the
// layout of a queued command word.
// Optional feature macro: SERVOS_PETELECO_EN (flick / return-to-previous mode).
package gerenciador_servos_pkg;

  // State codes are exported on db_estado, so their values are fixed.
  typedef enum logic [2:0] {
    OCIOSO     = 3'b000,
    CARREGA    = 3'b001,
    ESPERA     = 3'b010,
    RETORNA    = 3'b011,
    ESPERA_RET = 3'b100,
    FIM        = 3'b101
  } estado_t;

  // Queued command word layout, LSB first: servo index, target position,
  // then (flick builds only) the return flag in the MSB.
  function automatic int cmd_largura(input int servo_w, input int pos_w,
                                     input bit com_retorno);
    return servo_w + pos_w + (com_retorno ? 1 : 0);
  endfunction

endpackage

// File: rtl/gerenciador_servos_n_if.sv
// Command stream into the servo sequencer: valid/ready handshake plus the
// command fields. The move controller is the master, the sequencer the slave.
interface gerenciador_servos_n_if #(
  parameter int NUM_SERVOS = 3,
  parameter int POS_W      = 8
);
  localparam int SERVO_W = $clog2(NUM_SERVOS);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [SERVO_W-1:0] cmd_servo;
  logic [POS_W-1:0]   cmd_posicao;
  logic               cmd_retorno;

  modport master (
    output cmd_valid, cmd_servo, cmd_posicao, cmd_retorno,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_servo, cmd_posicao, cmd_retorno,
    output cmd_ready
  );
endinterface

// File: rtl/gerenciador_servos_n_fila_comandos.sv
// Synchronous command FIFO (fila_comandos) for the servo sequencer.
// Storage is a plain array with a registered read port so it can map to RAM;
// rd_data holds the entry popped on the previous clock.
module gerenciador_servos_n_fila_comandos #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = rd_data_reg;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Registered read of the head entry on pop.
  always_ff @(posedge clock) begin
    if (pop_ok) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/gerenciador_servos_n.sv
// Servo sequencer: queues position commands and executes them one at a time,
// updating the addressed channel, waiting a settling time, then pulsing pronto.
// Optional feature macro: SERVOS_PETELECO_EN -- when defined, a command with
// cmd_retorno set restores the channel's previous position after settling and
// waits a second settling period before pronto.
module gerenciador_servos_n
  import gerenciador_servos_pkg::*;
#(
  parameter int          NUM_SERVOS         = 3,
  parameter int          POS_W              = 8,
  parameter int          TEMPO_ASSENTAMENTO = 50000000,
  parameter int          FIFO_DEPTH         = 4,
  parameter int unsigned POS_REPOUSO        = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  gerenciador_servos_n_if.slave         cmd,
  output logic [NUM_SERVOS*POS_W-1:0]   posicao_servos,
  output logic                          ocupado,
  output logic                          pronto,
  output logic                          erro_servo,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_nivel,
  output logic [2:0]                    db_estado
);
  localparam int SERVO_W = $clog2(NUM_SERVOS);
  localparam int TIMER_W = $clog2(TEMPO_ASSENTAMENTO) + 1;
`ifdef SERVOS_PETELECO_EN
  localparam int CMD_W = cmd_largura(SERVO_W, POS_W, 1'b1);
`else
  localparam int CMD_W = cmd_largura(SERVO_W, POS_W, 1'b0);
`endif
  localparam logic [POS_W-1:0]   POS_REP   = POS_W'(POS_REPOUSO);
  localparam logic [TIMER_W-1:0] TEMPO_FIM = TIMER_W'(TEMPO_ASSENTAMENTO - 1);
  localparam logic [SERVO_W:0]   NUM_LIM   = (SERVO_W+1)'(NUM_SERVOS);

  estado_t            estado_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [POS_W-1:0]   pos_reg [NUM_SERVOS];

  logic [CMD_W-1:0]   cmd_entrada;
  logic [CMD_W-1:0]   cmd_cabeca;
  logic               fifo_cheia;
  logic               fifo_vazia;
  logic               fifo_push;
  logic               fifo_pop;
  logic [SERVO_W-1:0] servo_cab;
  logic [POS_W-1:0]   pos_cab;
  logic               servo_valido;

`ifdef SERVOS_PETELECO_EN
  logic [SERVO_W-1:0] servo_reg;
  logic [POS_W-1:0]   antigo_reg;
  logic               retorno_reg;
  logic [POS_W-1:0]   pos_atual;
  assign cmd_entrada = {cmd.cmd_retorno, cmd.cmd_posicao, cmd.cmd_servo};
`else
  logic unused_retorno;
  assign unused_retorno = cmd.cmd_retorno;
  assign cmd_entrada    = {cmd.cmd_posicao, cmd.cmd_servo};
`endif

  assign cmd.cmd_ready = !fifo_cheia && !reset;
  assign fifo_push     = cmd.cmd_valid && cmd.cmd_ready;
  assign fifo_pop      = (estado_reg == OCIOSO) && !fifo_vazia;

  gerenciador_servos_n_fila_comandos #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fila_comandos (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (cmd_entrada),
    .pop     (fifo_pop),
    .rd_data (cmd_cabeca),
    .full    (fifo_cheia),
    .empty   (fifo_vazia),
    .level   (fifo_nivel)
  );

  // The popped command is valid from the CARREGA cycle onwards.
  assign servo_cab    = cmd_cabeca[SERVO_W-1:0];
  assign pos_cab      = cmd_cabeca[SERVO_W +: POS_W];
  assign servo_valido = ({1'b0, servo_cab} < NUM_LIM);

  // Outputs decode directly from the state register, so they are glitch-free
  // and line up with the state they describe.
  assign pronto     = (estado_reg == FIM);
  assign erro_servo = (estado_reg == CARREGA) && !servo_valido;
  assign ocupado    = (estado_reg != OCIOSO) || !fifo_vazia;
  assign db_estado  = estado_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SERVOS; gi++) begin : g_canal
      assign posicao_servos[gi*POS_W +: POS_W] = pos_reg[gi];
    end
  endgenerate

`ifdef SERVOS_PETELECO_EN
  // Current value of the addressed channel, saved so a flick can undo it.
  always_comb begin
    pos_atual = pos_reg[0];
    for (int i = 0; i < NUM_SERVOS; i++) begin
      if (servo_cab == SERVO_W'(i)) pos_atual = pos_reg[i];
    end
  end
`endif

  // Sequencer FSM, settling timer and channel position bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg <= OCIOSO;
      timer_reg  <= '0;
      for (int i = 0; i < NUM_SERVOS; i++) pos_reg[i] <= POS_REP;
`ifdef SERVOS_PETELECO_EN
      servo_reg   <= '0;
      antigo_reg  <= POS_REP;
      retorno_reg <= 1'b0;
`endif
    end else begin
      case (estado_reg)
        OCIOSO: begin
          if (!fifo_vazia) estado_reg <= CARREGA;
        end
        CARREGA: begin
          if (!servo_valido) begin
            estado_reg <= OCIOSO;
          end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
              if (servo_cab == SERVO_W'(i)) pos_reg[i] <= pos_cab;
            end
            timer_reg  <= '0;
            estado_reg <= ESPERA;
`ifdef SERVOS_PETELECO_EN
            servo_reg   <= servo_cab;
            antigo_reg  <= pos_atual;
            retorno_reg <= cmd_cabeca[CMD_W-1];
`endif
          end
        end
        ESPERA: begin
          if (timer_reg == TEMPO_FIM) begin
`ifdef SERVOS_PETELECO_EN
            estado_reg <= retorno_reg ? RETORNA : FIM;
`else
            estado_reg <= FIM;
`endif
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
`ifdef SERVOS_PETELECO_EN
        RETORNA: begin
          for (int i = 0; i < NUM_SERVOS; i++) begin
            if (servo_reg == SERVO_W'(i)) pos_reg[i] <= antigo_reg;
          end
          timer_reg  <= '0;
          estado_reg <= ESPERA_RET;
        end
        ESPERA_RET: begin
          if (timer_reg == TEMPO_FIM) estado_reg <= FIM;
          else                        timer_reg  <= timer_reg + 1'b1;
        end
`endif
        FIM: begin
          estado_reg <= OCIOSO;
        end
        default: begin
          estado_reg <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: doc/gerenciador_servos_n.md
Name: gerenciador_servos_n

Overview:
Parametrised servo sequencer driving NUM_SERVOS position channels from one command stream. Commands (servo index, target position, return flag) are queued in a small FIFO and executed one at a time. Each execution updates the addressed servo's position register, then waits a fixed settling time, then pulses pronto. It sits between the cube-solving move controller and the per-servo PWM generators, which consume posicao_servos.

Parameters:
NUM_SERVOS, 3, number of servo channels (≥2)
POS_W, 8, width of one position value
TEMPO_ASSENTAMENTO, 50000000, settling cycles per move (≥1)
FIFO_DEPTH, 4, command queue depth (power of 2, ≥2)
POS_REPOUSO, 0, reset position loaded into every channel

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept (= !fifo_full; 0 while reset high)
cmd_servo  in  $clog2(NUM_SERVOS)  target channel index
cmd_posicao  in  POS_W  target position
cmd_retorno  in  1  flick mode: return to previous position after settle (SERVOS_PETELECO_EN only)
posicao_servos  out  NUM_SERVOS*POS_W  channel i at bits [i*POS_W +: POS_W]
ocupado  out  1  FSM not idle or queue non-empty
pronto  out  1  one-cycle pulse per completed command
erro_servo  out  1  one-cycle pulse on out-of-range index
fifo_nivel  out  $clog2(FIFO_DEPTH)+1  entries queued
db_estado  out  3  current state code

Behaviour:
- Reset (any time, including mid-move): FIFO flushed; all channels = POS_REPOUSO; timer = 0; state OCIOSO; pronto/erro_servo/ocupado = 0; db_estado = 000; fifo_nivel = 0.
- Push on cmd_valid & cmd_ready. When the FIFO is full, cmd_ready = 0 and the command is not taken; cmd_valid is ignored when low.
- States and codes: OCIOSO 000, CARREGA 001, ESPERA 010, RETORNA 011, ESPERA_RET 100, FIM 101; undefined codes → OCIOSO.
- OCIOSO: if FIFO non-empty, pop the head and go to CARREGA.
- CARREGA: if cmd_servo ≥ NUM_SERVOS, pulse erro_servo, write nothing, and go to OCIOSO with no pronto. Otherwise save the old channel value, write the new position, clear the timer, and go to ESPERA.
- ESPERA: timer +1 per cycle. At timer == TEMPO_ASSENTAMENTO-1, go to RETORNA if the return flag is set and the macro is defined, else to FIM.
- FIM: pronto = 1 for one cycle, then go to OCIOSO.
- Latency: command accepted in cycle t → new position visible at t+3 → pronto in cycle t+3+TEMPO_ASSENTAMENTO.
- Back-to-back commands: the next pop happens in the OCIOSO cycle after FIM. Pushes are allowed in every state.
- A push and a pop in the same cycle leave the level unchanged. A push to an empty FIFO is not visible to the FSM until the next cycle.
- Timer width: $clog2(TEMPO_ASSENTAMENTO)+1. The timer does not count outside the wait states.
- Channels not addressed keep their value indefinitely.

Optional Feature:
SERVOS_PETELECO_EN:
- Defined: cmd_retorno is latched with the command. RETORNA restores the saved old position and clears the timer. ESPERA_RET waits TEMPO_ASSENTAMENTO cycles, then goes to FIM. pronto therefore comes at t+4+2*TEMPO_ASSENTAMENTO.
- Undefined: cmd_retorno is ignored and not stored. RETORNA and ESPERA_RET are unreachable and omitted.

Decomposition:
- Package gerenciador_servos_pkg holds the state code constants and the command record layout (servo, posicao, retorno field widths).
- One sub-module, fila_comandos: a synchronous FIFO (synchronous reset flush, full/empty/level outputs, parametrised width and depth).
- The FSM, timer and position register bank stay in gerenciador_servos_n.

Test Plan:
- NUM_SERVOS=3, TEMPO=4. Accept (servo 1, pos 0x5A) at cycle 0 → channel 1 = 0x5A from cycle 3; pronto only in cycle 7; channels 0 and 2 stay at POS_REPOUSO.
- FIFO_DEPTH=4, FSM busy. Push 5 commands back-to-back → cmd_ready drops after the 4th, while one entry is already popped. All accepted commands complete in order, one pronto each, spaced TEMPO+3 cycles apart.
- cmd_servo=3 with NUM_SERVOS=3 → erro_servo pulses in the CARREGA cycle; no channel changes; no pronto; the next queued command executes normally.
- Assert reset during ESPERA with 2 entries queued → the next cycle shows all channels = POS_REPOUSO, fifo_nivel = 0, db_estado = 000, and no pronto afterwards.
- With SERVOS_PETELECO_EN: channel 0 = 0x10, command (0, 0x80, retorno=1) at cycle 0 → 0x80 at cycle 3, back to 0x10 at cycle 8, pronto at cycle 12 (TEMPO=4).
- Without the macro, the same command → channel 0 stays at 0x80; pronto at cycle 7.
